// File: rtl/mac_controller_if.sv
// rtl/mac_controller_if.sv - handshake and control bundle between the MAC sequencer and its datapath
interface mac_controller_if;
    logic       start;
    logic       CMReady;
    logic       ldArgs;
    logic [1:0] seli;
    logic       CMStart;
    logic       init0Acc;
    logic       ldAcc;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, CMReady,
        input  ldArgs, seli, CMStart, init0Acc, ldAcc, busy, done, error
    );

    modport slave (
        input  start, CMReady,
        output ldArgs, seli, CMStart, init0Acc, ldAcc, busy, done, error
    );
endinterface

// File: rtl/mac_controller.sv
// rtl/mac_controller.sv - 4-term complex MAC sequencer; MAC_CTRL_TIMEOUT_EN enables the WAITM timeout abort
module mac_controller #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    mac_controller_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STARTM = 3'd2;
    localparam logic [2:0] WAITM  = 3'd3;
    localparam logic [2:0] ACC    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    logic [2:0] state;
    logic [1:0] idx;
    logic       armed;
    logic       accept;

    // armed is the registered history, so a ready still high from the previous term cannot match
    assign accept = armed && bus.CMReady;

`ifdef MAC_CTRL_TIMEOUT_EN
    localparam int RAW_W = $clog2(TIMEOUT_CYCLES);
    localparam int CW    = (RAW_W < 6) ? 6 : ((RAW_W > 16) ? 16 : RAW_W);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tcnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            armed <= 1'b0;
`ifdef MAC_CTRL_TIMEOUT_EN
            tcnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) state <= LOAD;
                end
                LOAD: begin
                    idx   <= 2'd0;
                    state <= STARTM;
                end
                STARTM: begin
                    armed <= 1'b0;
                    state <= WAITM;
`ifdef MAC_CTRL_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAITM: begin
                    if (accept) begin
                        state <= ACC;
                    end else begin
                        if (!bus.CMReady) armed <= 1'b1;
`ifdef MAC_CTRL_TIMEOUT_EN
                        if (tcnt == TLIM) state <= ERR;
                        else              tcnt  <= tcnt + 1'b1;
`endif
                    end
                end
                ACC: begin
                    if (idx == 2'd3) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= STARTM;
                    end
                end
                DONE: begin
                    state <= bus.start ? LOAD : IDLE;
                end
                ERR: begin
                    if (bus.start) state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ldArgs   = 1'b0;
        bus.seli     = 2'd0;
        bus.CMStart  = 1'b0;
        bus.init0Acc = 1'b0;
        bus.ldAcc    = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (state)
            LOAD: begin
                bus.ldArgs   = 1'b1;
                bus.init0Acc = 1'b1;
                bus.busy     = 1'b1;
            end
            STARTM: begin
                bus.CMStart = 1'b1;
                bus.seli    = idx;
                bus.busy    = 1'b1;
            end
            WAITM: begin
                bus.seli = idx;
                bus.busy = 1'b1;
            end
            ACC: begin
                bus.ldAcc = 1'b1;
                bus.seli  = idx;
                bus.busy  = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
            end
            ERR: begin
`ifdef MAC_CTRL_TIMEOUT_EN
                bus.error = 1'b1;
`else
                bus.error = 1'b0;
`endif
            end
            default: ;
        endcase
    end
endmodule
